alu_seq: RTL and testbench

//  Parametrised multi-cycle ALU that succeeds the combinational datapath ALU: width-generic,

---
 rtl/alu_seq.sv | 189 ++++++++++++++++++
 tb/tb_alu_seq.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Multi-cycle ALU: registered Result/Flags {Z,N,C,V}, iterative shifts, optional iterative multiply.
// Define ALU_SEQ_MUL_EN to build the shift-add multiplier for AluOp 11; otherwise op 11 acts as PASS.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [3:0]       i_alu_op,
  input  logic [WIDTH-1:0] i_op1,
  input  logic [WIDTH-1:0] i_op2,
  input  logic [SHW-1:0]   i_sh_amt,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic [3:0]       o_flags
);

  localparam logic [3:0] OP_ADD = 4'd1, OP_SUB = 4'd2, OP_AND = 4'd3, OP_OR  = 4'd4,
                         OP_NOT = 4'd5, OP_LSL = 4'd6, OP_LSR = 4'd7, OP_ASR = 4'd8,
                         OP_ADC = 4'd9, OP_SBC = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
`ifdef ALU_SEQ_MUL_EN
    S_MUL   = 2'd3,
`endif
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_sh;
  logic [SHW-1:0]   r_cnt;
  logic             w_accept, w_go_shift, w_go_mul;
  logic             w_sh_out;
  logic [WIDTH-1:0] w_sh_next;

  function automatic logic [3:0] f_flags(input logic [WIDTH-1:0] r, input logic c, input logic v);
    return {(r == '0), r[WIDTH-1], c, v};
  endfunction

  // Returns {flags, result} for every op that completes in the accept cycle.
  function automatic logic [WIDTH+3:0] f_single(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b, input logic cin);
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] bb, r;
    logic             c, v, arith;
    sum = '0; bb = b; r = a; c = 1'b0; v = 1'b0; arith = 1'b0;
    case (op)
      OP_ADD: begin sum = {1'b0, a} + {1'b0, b}; arith = 1'b1; end
      OP_ADC: begin sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin}; arith = 1'b1; end
      OP_SUB: begin bb = ~b; sum = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, 1'b1}; arith = 1'b1; end
      OP_SBC: begin bb = ~b; sum = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, cin}; arith = 1'b1; end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_NOT: r = ~a;
      default: r = a;
    endcase
    if (arith) begin
      r = sum[WIDTH-1:0];
      c = sum[WIDTH];
      v = (a[WIDTH-1] == bb[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    end
    return {f_flags(r, c, v), r};
  endfunction

  function automatic logic [WIDTH:0] f_shift_step(input logic [3:0] op, input logic [WIDTH-1:0] x);
    logic signed [WIDTH-1:0] xs;
    xs = x;
    case (op)
      OP_LSL:  return {x[WIDTH-1], x << 1};
      OP_ASR:  return {x[0], WIDTH'(xs >>> 1)};
      default: return {x[0], x >> 1};
    endcase
  endfunction

  assign w_accept   = (r_state == S_IDLE) && i_start;
  assign w_go_shift = ((i_alu_op == OP_LSL) || (i_alu_op == OP_LSR) || (i_alu_op == OP_ASR))
                      && (i_sh_amt != '0);
  assign {w_sh_out, w_sh_next} = f_shift_step(r_op, r_sh);

`ifdef ALU_SEQ_MUL_EN
  localparam int MCW = $clog2(WIDTH + 1);
  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_prod;
  logic [MCW-1:0]     r_mcnt;
  logic [WIDTH:0]     w_madd;
  logic [2*WIDTH-1:0] w_prod_next;

  assign w_go_mul = (i_alu_op == 4'd11);

  // Shift-add: add multiplicand into the upper half when the current multiplier bit is set.
  always_comb begin
    w_madd      = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
    w_prod_next = {w_madd, r_prod[WIDTH-1:1]};
  end
`else
  assign w_go_mul = 1'b0;
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_go_shift) w_state_next = S_SHIFT;
`ifdef ALU_SEQ_MUL_EN
          else if (w_go_mul) w_state_next = S_MUL;
`endif
          else w_state_next = S_DONE;
        end
      end
      S_SHIFT: if (r_cnt == SHW'(1)) w_state_next = S_DONE;
`ifdef ALU_SEQ_MUL_EN
      S_MUL:   if (r_mcnt == MCW'(1)) w_state_next = S_DONE;
`endif
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy = 1'b0;
    o_done = 1'b0;
    case (r_state)
      S_SHIFT: o_busy = 1'b1;
`ifdef ALU_SEQ_MUL_EN
      S_MUL:   o_busy = 1'b1;
`endif
      S_DONE:  o_done = 1'b1;
      default: ;
    endcase
  end

  // Working registers: captured at accept, stepped while iterating.
  always_ff @(posedge i_clock) begin
    if (w_accept) begin
      r_op  <= i_alu_op;
      r_sh  <= i_op1;
      r_cnt <= i_sh_amt;
`ifdef ALU_SEQ_MUL_EN
      r_mcand <= i_op1;
      r_prod  <= {{WIDTH{1'b0}}, i_op2};
      r_mcnt  <= MCW'(WIDTH);
`endif
    end else if (r_state == S_SHIFT) begin
      r_sh  <= w_sh_next;
      r_cnt <= r_cnt - SHW'(1);
    end
`ifdef ALU_SEQ_MUL_EN
    else if (r_state == S_MUL) begin
      r_prod <= w_prod_next;
      r_mcnt <= r_mcnt - MCW'(1);
    end
`endif
  end

  // Architectural outputs change only on the edge that enters the Done cycle.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_result <= '0;
      r_flags  <= 4'b0000;
    end else if (w_accept && !w_go_shift && !w_go_mul) begin
      {r_flags, r_result} <= f_single(i_alu_op, i_op1, i_op2, r_flags[1]);
    end else if ((r_state == S_SHIFT) && (r_cnt == SHW'(1))) begin
      r_result <= w_sh_next;
      r_flags  <= f_flags(w_sh_next, w_sh_out, 1'b0);
    end
`ifdef ALU_SEQ_MUL_EN
    else if ((r_state == S_MUL) && (r_mcnt == MCW'(1))) begin
      r_result <= w_prod_next[WIDTH-1:0];
      r_flags  <= f_flags(w_prod_next[WIDTH-1:0], |w_prod_next[2*WIDTH-1:WIDTH], 1'b0);
    end
`endif
  end

  assign o_result = r_result;
  assign o_flags  = r_flags;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=16, SHW=5 so shift distances >= WIDTH can be driven).
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  alu_op = 4'd0;
  logic [15:0] op1 = '0, op2 = '0;
  logic [4:0]  sh_amt = '0;
  logic        busy, done;
  logic [15:0] result;
  logic [3:0]  flags;

  int n_pass = 0;
  int n_total = 0;

  alu_seq #(.WIDTH(16), .SHW(5)) dut (
    .i_clock(clk), .i_reset(rst), .i_start(start), .i_alu_op(alu_op),
    .i_op1(op1), .i_op2(op2), .i_sh_amt(sh_amt),
    .o_busy(busy), .o_done(done), .o_result(result), .o_flags(flags)
  );

  always #5 clk = ~clk;

  // Launches one op starting at the next negedge; returns Done latency and Busy cycle count.
  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [4:0] sh, output int lat, output int busy_n);
    @(negedge clk);
    alu_op = op; op1 = a; op2 = b; sh_amt = sh; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op1 = 16'hDEAD; op2 = 16'hBEEF; sh_amt = 5'd3; alu_op = 4'd4;
    lat = 1; busy_n = 0;
    while (!done && lat < 100) begin
      if (busy) busy_n++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); @(negedge clk); rst = 1'b0;
    @(negedge clk);
    n_total++; if (result !== 16'h0000) $display("FAIL reset_result got %h want 0000", result); else n_pass++;
    n_total++; if (flags !== 4'b0000) $display("FAIL reset_flags got %b want 0000", flags); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
  endtask

  task automatic test_add();
    int lat, bn;
    run_op(4'd1, 16'h7FFF, 16'h0001, 5'd0, lat, bn);
    n_total++; if (lat !== 1) $display("FAIL add_latency got %0d want 1", lat); else n_pass++;
    n_total++; if (bn !== 0) $display("FAIL add_busy got %0d want 0", bn); else n_pass++;
    n_total++; if (result !== 16'h8000) $display("FAIL add_result got %h want 8000", result); else n_pass++;
    n_total++; if (flags !== 4'b0101) $display("FAIL add_flags got %b want 0101", flags); else n_pass++;
  endtask

  task automatic test_sub_sbc_adc();
    int lat, bn;
    run_op(4'd2, 16'h0003, 16'h0005, 5'd0, lat, bn);
    n_total++; if (result !== 16'hFFFE) $display("FAIL sub_result got %h want fffe", result); else n_pass++;
    n_total++; if (flags !== 4'b0100) $display("FAIL sub_flags got %b want 0100", flags); else n_pass++;
    run_op(4'd10, 16'h0005, 16'h0003, 5'd0, lat, bn);
    n_total++; if (result !== 16'h0001) $display("FAIL sbc_result got %h want 0001", result); else n_pass++;
    n_total++; if (flags !== 4'b0010) $display("FAIL sbc_flags got %b want 0010", flags); else n_pass++;
    run_op(4'd9, 16'h0001, 16'h0001, 5'd0, lat, bn);
    n_total++; if (result !== 16'h0003) $display("FAIL adc_result got %h want 0003", result); else n_pass++;
    n_total++; if (flags !== 4'b0000) $display("FAIL adc_flags got %b want 0000", flags); else n_pass++;
  endtask

  task automatic test_logic();
    int lat, bn;
    run_op(4'd2, 16'h0005, 16'h0003, 5'd0, lat, bn);
    run_op(4'd3, 16'hF0F0, 16'h3C3C, 5'd0, lat, bn);
    n_total++; if ({flags, result} !== {4'b0000, 16'h3030}) $display("FAIL and_out got %b/%h want 0000/3030", flags, result); else n_pass++;
    run_op(4'd4, 16'h8000, 16'h0001, 5'd0, lat, bn);
    n_total++; if ({flags, result} !== {4'b0100, 16'h8001}) $display("FAIL or_out got %b/%h want 0100/8001", flags, result); else n_pass++;
    run_op(4'd5, 16'hFFFF, 16'h1234, 5'd0, lat, bn);
    n_total++; if ({flags, result} !== {4'b1000, 16'h0000}) $display("FAIL not_out got %b/%h want 1000/0000", flags, result); else n_pass++;
    run_op(4'd13, 16'h1234, 16'h5678, 5'd0, lat, bn);
    n_total++; if ({flags, result} !== {4'b0000, 16'h1234}) $display("FAIL undef_op got %b/%h want 0000/1234", flags, result); else n_pass++;
  endtask

  task automatic test_shift();
    int lat, bn;
    // ASR with Start held high through Busy and the Done cycle.
    @(negedge clk);
    alu_op = 4'd8; op1 = 16'h8010; op2 = 16'h0000; sh_amt = 5'd4; start = 1'b1;
    @(negedge clk);
    alu_op = 4'd1; op1 = 16'h0001; op2 = 16'h0001; sh_amt = 5'd0;
    lat = 1; bn = 0;
    while (!done && lat < 100) begin
      if (busy) bn++;
      @(negedge clk);
      lat++;
    end
    n_total++; if (lat !== 5) $display("FAIL asr_latency got %0d want 5", lat); else n_pass++;
    n_total++; if (bn !== 4) $display("FAIL asr_busy got %0d want 4", bn); else n_pass++;
    n_total++; if ({flags, result} !== {4'b0100, 16'hF801}) $display("FAIL asr_out got %b/%h want 0100/f801", flags, result); else n_pass++;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    n_total++; if ({busy, done, result} !== {2'b00, 16'hF801}) $display("FAIL start_ignored got %b%b/%h want 00/f801", busy, done, result); else n_pass++;

    run_op(4'd6, 16'h0001, 16'h0000, 5'd16, lat, bn);
    n_total++; if (lat !== 17) $display("FAIL lsl16_latency got %0d want 17", lat); else n_pass++;
    n_total++; if ({flags, result} !== {4'b1010, 16'h0000}) $display("FAIL lsl16_out got %b/%h want 1010/0000", flags, result); else n_pass++;
    run_op(4'd6, 16'h0001, 16'h0000, 5'd0, lat, bn);
    n_total++; if (lat !== 1) $display("FAIL lsl0_latency got %0d want 1", lat); else n_pass++;
    n_total++; if ({flags, result} !== {4'b0000, 16'h0001}) $display("FAIL lsl0_out got %b/%h want 0000/0001", flags, result); else n_pass++;
    run_op(4'd7, 16'h8001, 16'h0000, 5'd1, lat, bn);
    n_total++; if ({flags, result} !== {4'b0010, 16'h4000}) $display("FAIL lsr1_out got %b/%h want 0010/4000", flags, result); else n_pass++;
    run_op(4'd8, 16'h8000, 16'h0000, 5'd20, lat, bn);
    n_total++; if (lat !== 21) $display("FAIL asr20_latency got %0d want 21", lat); else n_pass++;
    n_total++; if ({flags, result} !== {4'b0110, 16'hFFFF}) $display("FAIL asr20_out got %b/%h want 0110/ffff", flags, result); else n_pass++;
  endtask

  task automatic test_mul();
    int lat, bn;
    run_op(4'd11, 16'h0100, 16'h0101, 5'd0, lat, bn);
`ifdef ALU_SEQ_MUL_EN
    n_total++; if (lat !== 17) $display("FAIL mul_latency got %0d want 17", lat); else n_pass++;
    n_total++; if (bn !== 16) $display("FAIL mul_busy got %0d want 16", bn); else n_pass++;
    n_total++; if ({flags, result} !== {4'b0010, 16'h0100}) $display("FAIL mul_out got %b/%h want 0010/0100", flags, result); else n_pass++;
    run_op(4'd11, 16'h0007, 16'h0009, 5'd0, lat, bn);
    n_total++; if ({flags, result} !== {4'b0000, 16'h003F}) $display("FAIL mul_small got %b/%h want 0000/003f", flags, result); else n_pass++;
`else
    n_total++; if (lat !== 1) $display("FAIL op11_latency got %0d want 1", lat); else n_pass++;
    n_total++; if ({flags, result} !== {4'b0000, 16'h0100}) $display("FAIL op11_out got %b/%h want 0000/0100", flags, result); else n_pass++;
`endif
  endtask

  task automatic test_back_to_back();
    int lat, bn;
    run_op(4'd1, 16'h1000, 16'h0234, 5'd0, lat, bn);
    n_total++; if ({lat, result} !== {32'd1, 16'h1234}) $display("FAIL b2b_first got %0d/%h want 1/1234", lat, result); else n_pass++;
    run_op(4'd2, 16'h0010, 16'h0011, 5'd0, lat, bn);
    n_total++; if ({lat, flags, result} !== {32'd1, 4'b0100, 16'hFFFF}) $display("FAIL b2b_second got %0d/%b/%h want 1/0100/ffff", lat, flags, result); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    alu_op = 4'd6; op1 = 16'h00FF; sh_amt = 5'd10; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_total++; if ({busy, done, flags, result} !== {2'b00, 4'b0000, 16'h0000}) $display("FAIL midreset_out got %b%b/%b/%h want 00/0000/0000", busy, done, flags, result); else n_pass++;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    n_total++; if (seen !== 0) $display("FAIL midreset_no_done got %0d active cycles want 0", seen); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_sbc_adc();
    test_logic();
    test_shift();
    test_mul();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
